// File: rtl/i2c_target_pkg.sv
// i2c_target_pkg: shared types and constants for the I2C target.
//   byte_t             8-bit data byte carried on the bus and user interface
//   address_t          7-bit I2C bus address
//   ACKT_t             ACK slot level (ACK_T = line low, NACK_T = line released)
//   i2c_target_state_t protocol FSM states of the target
package i2c_target_pkg;

    typedef logic [7:0] byte_t;
    typedef logic [6:0] address_t;

    typedef logic ACKT_t;
    localparam ACKT_t ACK_T  = 1'b0;
    localparam ACKT_t NACK_T = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        WR_DATA,
        WR_ACK,
        RD_DATA,
        RD_ACK
    } i2c_target_state_t;

endpackage

// File: rtl/i2c_line_sync.sv
// i2c_line_sync: synchronizes raw SCL/SDA into the clk domain and derives bus events.
// Ports:
//   clk, rst   system clock, synchronous active-high reset
//   scl_i      raw SCL level
//   sda_i      raw SDA level
//   scl_rise   one-cycle pulse on a synchronized SCL 0->1
//   scl_fall   one-cycle pulse on a synchronized SCL 1->0
//   start_det  one-cycle pulse on SDA 1->0 while SCL is high
//   stop_det   one-cycle pulse on SDA 0->1 while SCL is high
//   sda_s      synchronized SDA level
module i2c_line_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic scl_i,
    input  logic sda_i,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic sda_s
);

    logic [SYNC_STAGES-1:0] scl_sync_q;
    logic [SYNC_STAGES-1:0] sda_sync_q;
    logic                   scl_hist_q;
    logic                   sda_hist_q;
    logic                   scl_s;

    // Reset to the idle-bus level so no spurious event fires when reset releases.
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_hist_q <= 1'b1;
            sda_hist_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
            scl_hist_q <= scl_sync_q[SYNC_STAGES-1];
            sda_hist_q <= sda_sync_q[SYNC_STAGES-1];
        end
    end

    assign scl_s = scl_sync_q[SYNC_STAGES-1];
    assign sda_s = sda_sync_q[SYNC_STAGES-1];

    assign scl_rise  = scl_s & ~scl_hist_q;
    assign scl_fall  = ~scl_s & scl_hist_q;
    // SCL must be high in both samples so an SDA edge coincident with an SCL edge is not a START/STOP.
    assign start_det = sda_hist_q & ~sda_s & scl_s & scl_hist_q;
    assign stop_det  = ~sda_hist_q & sda_s & scl_s & scl_hist_q;

endmodule

// File: rtl/i2c_target.sv
// i2c_target: single-address I2C target (slave), no clock stretching.
// Ports:
//   clk, rst   system clock (>= 16x SCL), synchronous active-high reset
//   scl_i      raw SCL level
//   sda_i      raw SDA level
//   sda_oe     1 pulls SDA low, 0 releases it
//   rx_data    last accepted write byte
//   rx_valid   one-cycle pulse when rx_data is new
//   rx_ready   user can accept a byte, sampled at the write ACK decision
//   tx_data    byte to return on a read; must be stable while tx_req is requested
//   tx_req     one-cycle pulse, tx_data has just been loaded into the shifter
//   busy       high from an address match until STOP, START with mismatch, or reset
module i2c_target
    import i2c_target_pkg::*;
#(
    parameter address_t    TARGET_ADDR = 7'h50,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  scl_i,
    input  logic  sda_i,
    output logic  sda_oe,
    output byte_t rx_data,
    output logic  rx_valid,
    input  logic  rx_ready,
    input  byte_t tx_data,
    output logic  tx_req,
    output logic  busy
);

    logic scl_rise;
    logic scl_fall;
    logic start_det;
    logic stop_det;
    logic sda_s;

    i2c_line_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_line_sync (
        .clk      (clk),
        .rst      (rst),
        .scl_i    (scl_i),
        .sda_i    (sda_i),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start_det(start_det),
        .stop_det (stop_det),
        .sda_s    (sda_s)
    );

    i2c_target_state_t state_q;
    logic [2:0]        bit_cnt_q;
    byte_t             shift_q;
    logic              rw_q;
    // Set once a full byte (or the master's ACK bit) has been sampled; the
    // following scl_fall then performs the slot action.
    logic              byte_done_q;
    ACKT_t             mack_q;
    logic              sda_oe_q;
    byte_t             rx_data_q;
    logic              rx_valid_q;
    logic              tx_req_q;
    logic              busy_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'h00;
            rw_q        <= 1'b0;
            byte_done_q <= 1'b0;
            mack_q      <= NACK_T;
            sda_oe_q    <= 1'b0;
            rx_data_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
            tx_req_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            tx_req_q   <= 1'b0;
            if (stop_det) begin
                state_q     <= IDLE;
                sda_oe_q    <= 1'b0;
                busy_q      <= 1'b0;
                byte_done_q <= 1'b0;
            end else if (start_det) begin
                // Also a repeated START: busy is kept until the address is re-checked.
                state_q     <= ADDR;
                bit_cnt_q   <= 3'd0;
                byte_done_q <= 1'b0;
                sda_oe_q    <= 1'b0;
            end else begin
                unique case (state_q)
                    IDLE: begin
                    end
                    ADDR: begin
                        if (!byte_done_q) begin
                            if (scl_rise) begin
                                shift_q   <= {shift_q[6:0], sda_s};
                                bit_cnt_q <= bit_cnt_q + 3'd1;
                                if (bit_cnt_q == 3'd7) begin
                                    // shift_q[6:0] holds the seven address bits; sda_s is R/W.
                                    if (shift_q[6:0] == TARGET_ADDR) begin
                                        busy_q      <= 1'b1;
                                        rw_q        <= sda_s;
                                        byte_done_q <= 1'b1;
                                    end else begin
                                        busy_q  <= 1'b0;
                                        state_q <= IDLE;
                                    end
                                end
                            end
                        end else if (scl_fall) begin
                            sda_oe_q    <= 1'b1;
                            byte_done_q <= 1'b0;
                            state_q     <= ADDR_ACK;
                        end
                    end
                    ADDR_ACK: begin
                        if (scl_fall) begin
                            bit_cnt_q <= 3'd0;
                            if (!rw_q) begin
                                sda_oe_q <= 1'b0;
                                state_q  <= WR_DATA;
                            end else begin
                                tx_req_q <= 1'b1;
                                shift_q  <= tx_data;
                                sda_oe_q <= ~tx_data[7];
                                state_q  <= RD_DATA;
                            end
                        end
                    end
                    WR_DATA: begin
                        if (!byte_done_q) begin
                            if (scl_rise) begin
                                shift_q   <= {shift_q[6:0], sda_s};
                                bit_cnt_q <= bit_cnt_q + 3'd1;
                                if (bit_cnt_q == 3'd7) begin
                                    byte_done_q <= 1'b1;
                                end
                            end
                        end else if (scl_fall) begin
                            byte_done_q <= 1'b0;
                            state_q     <= WR_ACK;
                            if (rx_ready) begin
                                rx_valid_q <= 1'b1;
                                rx_data_q  <= shift_q;
                                sda_oe_q   <= 1'b1;
                            end
                        end
                    end
                    WR_ACK: begin
                        if (scl_fall) begin
                            sda_oe_q <= 1'b0;
                            state_q  <= WR_DATA;
                        end
                    end
                    RD_DATA: begin
                        if (scl_fall) begin
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) begin
                                sda_oe_q    <= 1'b0;
                                byte_done_q <= 1'b0;
                                state_q     <= RD_ACK;
                            end else begin
                                sda_oe_q <= ~shift_q[6];
                                shift_q  <= {shift_q[6:0], 1'b0};
                            end
                        end
                    end
                    RD_ACK: begin
                        if (!byte_done_q) begin
                            if (scl_rise) begin
                                mack_q      <= sda_s;
                                byte_done_q <= 1'b1;
                            end
                        end else if (scl_fall && (mack_q == ACK_T)) begin
                            // After a NACK byte_done_q stays set: park here until STOP/START.
                            byte_done_q <= 1'b0;
                            bit_cnt_q   <= 3'd0;
                            tx_req_q    <= 1'b1;
                            shift_q     <= tx_data;
                            sda_oe_q    <= ~tx_data[7];
                            state_q     <= RD_DATA;
                        end
                    end
                    default: begin
                        state_q  <= IDLE;
                        sda_oe_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign sda_oe   = sda_oe_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign tx_req   = tx_req_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_i2c_target.sv
// tb_i2c_target: bus-master stimulus with a scoreboard for rx_valid / tx_req events.
module tb_i2c_target;
    import i2c_target_pkg::*;

    localparam int Q = 5;  // clk cycles per quarter SCL period (20x oversampling)

    logic  clk      = 1'b0;
    logic  rst      = 1'b1;
    logic  scl      = 1'b1;
    logic  sda_m    = 1'b1;
    logic  rx_ready = 1'b1;
    byte_t tx_data  = 8'h00;
    logic  sda_oe;
    byte_t rx_data;
    logic  rx_valid;
    logic  tx_req;
    logic  busy;
    logic  sda_bus;

    assign sda_bus = sda_m & ~sda_oe;

    always #5 clk = ~clk;

    i2c_target #(
        .TARGET_ADDR(7'h50),
        .SYNC_STAGES(2)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .scl_i   (scl),
        .sda_i   (sda_bus),
        .sda_oe  (sda_oe),
        .rx_data (rx_data),
        .rx_valid(rx_valid),
        .rx_ready(rx_ready),
        .tx_data (tx_data),
        .tx_req  (tx_req),
        .busy    (busy)
    );

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct packed {
        logic  is_tx;
        byte_t data;
    } exp_t;

    exp_t exp_q[$];

    logic watch_oe = 1'b0;
    logic saw_oe   = 1'b0;

    task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
    endtask

    task automatic push_rx(input byte_t d);
        exp_t e;
        e.is_tx = 1'b0;
        e.data  = d;
        exp_q.push_back(e);
    endtask

    task automatic push_tx();
        exp_t e;
        e.is_tx = 1'b1;
        e.data  = 8'h00;
        exp_q.push_back(e);
    endtask

    task automatic mon_event(input logic is_tx, input byte_t d);
        exp_t e;
        check_eq(is_tx ? "tx_req expected" : "rx_valid expected", (exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_eq("event kind", is_tx, e.is_tx);
            if (!is_tx) check_eq("rx_data", d, e.data);
        end
    endtask

    // Scoreboard monitor
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (rx_valid) mon_event(1'b0, rx_data);
                if (tx_req) mon_event(1'b1, 8'h00);
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (watch_oe && sda_oe) saw_oe = 1'b1;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_start();
        sda_m = 1'b1; tick(Q);
        scl   = 1'b1; tick(Q);
        sda_m = 1'b0; tick(Q);
        scl   = 1'b0; tick(Q);
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; tick(Q);
        scl   = 1'b1; tick(Q);
        sda_m = 1'b1; tick(2 * Q);
    endtask

    task automatic bus_bit(input logic b, output logic s);
        sda_m = b;    tick(Q);
        scl   = 1'b1; tick(Q);
        s     = sda_bus; tick(Q);
        scl   = 1'b0; tick(Q);
    endtask

    task automatic write_byte(input byte_t d, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bus_bit(d[i], s);
        bus_bit(1'b1, ack);
    endtask

    task automatic read_byte(input logic mack, output byte_t d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            bus_bit(1'b1, s);
            d[i] = s;
        end
        bus_bit(mack, s);
    endtask

    initial begin
        logic  ack;
        logic  s;
        byte_t d;

        rst = 1'b1;
        tick(4);
        check_eq("reset sda_oe", sda_oe, 0);
        check_eq("reset rx_data", rx_data, 8'h00);
        check_eq("reset rx_valid", rx_valid, 0);
        check_eq("reset tx_req", tx_req, 0);
        check_eq("reset busy", busy, 0);
        rst = 1'b0;
        tick(4);

        // Write 0xA5 to 0x50
        push_rx(8'hA5);
        bus_start();
        write_byte(8'hA0, ack);
        check_eq("t1 addr ack", ack, 0);
        check_eq("t1 busy", busy, 1);
        write_byte(8'hA5, ack);
        check_eq("t1 data ack", ack, 0);
        bus_stop();
        check_eq("t1 busy after stop", busy, 0);
        check_eq("t1 queue drained", exp_q.size(), 0);

        // Wrong address 0x51
        saw_oe   = 1'b0;
        watch_oe = 1'b1;
        bus_start();
        write_byte(8'hA2, ack);
        check_eq("t2 addr nack", ack, 1);
        check_eq("t2 busy", busy, 0);
        write_byte(8'hFF, ack);
        check_eq("t2 data nack", ack, 1);
        bus_stop();
        watch_oe = 1'b0;
        check_eq("t2 sda_oe never set", saw_oe, 0);

        // Read 0x3C (ACK) then 0x81 (NACK)
        tx_data = 8'h3C;
        push_tx();
        push_tx();
        bus_start();
        write_byte(8'hA1, ack);
        check_eq("t3 addr ack", ack, 0);
        tx_data = 8'h81;
        read_byte(1'b0, d);
        check_eq("t3 byte0", d, 8'h3C);
        read_byte(1'b1, d);
        check_eq("t3 byte1", d, 8'h81);
        bus_bit(1'b1, s);
        check_eq("t3 sda released after nack", s, 1);
        check_eq("t3 sda_oe after nack", sda_oe, 0);
        bus_stop();
        check_eq("t3 queue drained", exp_q.size(), 0);

        // rx_ready low -> data NACK
        rx_ready = 1'b0;
        bus_start();
        write_byte(8'hA0, ack);
        check_eq("t4 addr ack", ack, 0);
        write_byte(8'h12, ack);
        check_eq("t4 data nack", ack, 1);
        bus_stop();
        rx_ready = 1'b1;
        check_eq("t4 queue drained", exp_q.size(), 0);

        // Write 0x77, repeated START, read 0xC3
        push_rx(8'h77);
        bus_start();
        write_byte(8'hA0, ack);
        check_eq("t5 addr ack", ack, 0);
        write_byte(8'h77, ack);
        check_eq("t5 data ack", ack, 0);
        check_eq("t5 busy before rs", busy, 1);
        tx_data = 8'hC3;
        push_tx();
        bus_start();
        check_eq("t5 busy after rs", busy, 1);
        write_byte(8'hA1, ack);
        check_eq("t5 read addr ack", ack, 0);
        read_byte(1'b1, d);
        check_eq("t5 read byte", d, 8'hC3);
        check_eq("t5 busy during read", busy, 1);
        check_eq("t5 rx_data held", rx_data, 8'h77);
        bus_stop();
        check_eq("t5 queue drained", exp_q.size(), 0);

        // Reset in the middle of a read of 0x00
        tx_data = 8'h00;
        push_tx();
        bus_start();
        write_byte(8'hA1, ack);
        check_eq("t6 addr ack", ack, 0);
        for (int i = 0; i < 3; i++) begin
            bus_bit(1'b1, s);
            check_eq("t6 read bit", s, 0);
        end
        sda_m = 1'b1;
        tick(Q);
        check_eq("t6 sda_oe before rst", sda_oe, 1);
        rst = 1'b1;
        tick(1);
        check_eq("t6 sda_oe after rst", sda_oe, 0);
        tick(2);
        rst = 1'b0;
        tick(2);
        check_eq("t6 busy after rst", busy, 0);
        bus_stop();
        push_rx(8'h5A);
        bus_start();
        write_byte(8'hA0, ack);
        check_eq("t6 write addr ack", ack, 0);
        write_byte(8'h5A, ack);
        check_eq("t6 write data ack", ack, 0);
        bus_stop();
        check_eq("t6 rx_data", rx_data, 8'h5A);
        check_eq("t6 queue drained", exp_q.size(), 0);

        tick(10);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
